// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// bit-counter width helper. Optional feature macro: SERIAL_SUB_EN.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Counter must hold 0..WIDTH without wrapping inside a run.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// Optional feature macro: SERIAL_SUB_EN (adds the sub select line).
interface serial_add_ctrl_if #(parameter int WIDTH = 8);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_SUB_EN
      output sub,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_SUB_EN
      input  sub,
`endif
      output busy, done, sum, cout
   );

endinterface

// File: rtl/serial_add_ctrl_dp.sv
// Datapath of the bit-serial adder: one full-adder cell, the carry flop and
// the operand/sum shift registers. Optional feature macro: SERIAL_SUB_EN
// (operand B is inverted and the carry forced to 1 for subtraction).
module serial_add_dp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   input  logic             load,
   input  logic             shift,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_next;
   logic             carry_reg;
   logic             cout_reg;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;
   logic             fa_s;
   logic             fa_c;

`ifdef SERIAL_SUB_EN
   // Two's-complement subtract: a + ~b + 1.
   assign b_load   = sub ? ~b : b;
   assign cin_load = sub ? 1'b1 : cin;
`else
   assign b_load   = b;
   assign cin_load = cin;
`endif

   assign fa_s = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
   assign fa_c = (a_sr_reg[0] & b_sr_reg[0]) | (carry_reg & (a_sr_reg[0] ^ b_sr_reg[0]));

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      if (gi == WIDTH - 1) begin : g_top
         assign sum_next[gi] = fa_s;
      end else begin : g_mid
         assign sum_next[gi] = sum_reg[gi+1];
      end
   end

   // Load operands on accept, otherwise shift one bit per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_reg  <= '0;
         b_sr_reg  <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
      end else if (load) begin
         a_sr_reg  <= a;
         b_sr_reg  <= b_load;
         carry_reg <= cin_load;
         sum_reg   <= '0;
      end else if (shift) begin
         a_sr_reg  <= a_sr_reg >> 1;
         b_sr_reg  <= b_sr_reg >> 1;
         carry_reg <= fa_c;
         sum_reg   <= sum_next;
         if (last) begin
            cout_reg <= fa_c;
         end
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE,
// driving the serial_add_dp load/shift enables and the busy/done handshake.
// Optional feature macro: SERIAL_SUB_EN (subtract select on the bus).
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_add_ctrl_if.slave   bus
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             load;
   logic             shift;
   logic             last;

   assign load  = (state_reg == ST_IDLE) && bus.start;
   assign shift = (state_reg == ST_RUN);
   assign last  = shift && (cnt_reg == CNT_LAST);

   // Sequencer FSM with registered busy/done; start outside IDLE is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  state_reg <= ST_RUN;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            ST_RUN: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   serial_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef SERIAL_SUB_EN
      .sub   (bus.sub),
`endif
      .load  (load),
      .shift (shift),
      .last  (last),
      .a     (bus.a),
      .b     (bus.b),
      .cin   (bus.cin),
      .sum   (bus.sum),
      .cout  (bus.cout)
   );

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Optional feature macro: SERIAL_SUB_EN enables the subtract checks.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: {cout,sum} as plain 9-bit arithmetic.
   function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
      if (sub)
         return {1'b0, a} + 9'd256 - {1'b0, b};
      else
         return {1'b0, a} + {1'b0, b} + {8'd0, cin};
   endfunction

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic start);
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = cin;
      bus8.start = start;
`ifdef SERIAL_SUB_EN
      bus8.sub   = sub;
`else
      if (sub) $display("note: sub ignored in add-only build");
`endif
   endtask

   // Called at a negedge while the DUT is IDLE. Returns result captured at the
   // done pulse, the cycle number of that pulse, busy cycle count, and the sum
   // one cycle later (must be held).
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic [7:0] s, output logic co,
                       output int done_cyc, output int busy_cyc, output logic [7:0] s_hold);
      s = '0; co = 1'b0; done_cyc = -1; busy_cyc = 0;
      drive8(a, b, cin, sub, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (bus8.busy) busy_cyc++;
         if (bus8.done) begin
            done_cyc = k; s = bus8.sum; co = bus8.cout;
            break;
         end
      end
      @(negedge clk);
      s_hold = bus8.sum;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [6];
      logic [7:0] s, s_hold, ra, rb;
      logic co, rc, rs;
      logic [8:0] r;
      int dc, bc, pulses;

      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SERIAL_SUB_EN
      bus1.sub = 1'b0;
`endif
      drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset state
      #1;
      check("reset_busy", {31'd0, bus8.busy}, 32'd0);
      check("reset_done", {31'd0, bus8.done}, 32'd0);
      check("reset_sum",  {24'd0, bus8.sum},  32'd0);
      check("reset_cout", {31'd0, bus8.cout}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, dc, bc, s_hold);
         $display("vec %0d: %02h+%02h+%0d -> sum=%02h cout=%0d done_cycle=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, dc);
         check("vec_done_cycle", dc, 32'd9);
         check("vec_busy_cycles", bc, 32'd8);
         check("vec_sum",  {24'd0, s},  {24'd0, vecs[i].exp_sum});
         check("vec_cout", {31'd0, co}, {31'd0, vecs[i].exp_cout});
         check("vec_sum_hold", {24'd0, s_hold}, {24'd0, vecs[i].exp_sum});
      end

      // Start during RUN is ignored
      drive8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      pulses = 0; dc = -1; s = '0;
      for (int k = 1; k <= 15; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 3) drive8(8'hF0, 8'h01, 1'b0, 1'b0, 1'b1);
         if (k == 4) drive8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
         if (bus8.done) begin
            pulses++;
            if (dc < 0) begin dc = k; s = bus8.sum; end
         end
      end
      $display("ignore-start: sum=%02h pulses=%0d done_cycle=%0d", s, pulses, dc);
      check("ign_pulses", pulses, 32'd1);
      check("ign_done_cycle", dc, 32'd9);
      check("ign_sum", {24'd0, s}, 32'h02);

      // Leave cout=1, then reset mid-run
      run8(8'hFF, 8'h01, 1'b0, 1'b0, s, co, dc, bc, s_hold);
      drive8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("mid-run reset: busy=%0d done=%0d sum=%02h cout=%0d",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
      check("rst_busy", {31'd0, bus8.busy}, 32'd0);
      check("rst_done", {31'd0, bus8.done}, 32'd0);
      check("rst_sum",  {24'd0, bus8.sum},  32'd0);
      check("rst_cout", {31'd0, bus8.cout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run8(8'h03, 8'h04, 1'b0, 1'b0, s, co, dc, bc, s_hold);
      $display("after reset: 03+04 -> sum=%02h done_cycle=%0d", s, dc);
      check("post_rst_done_cycle", dc, 32'd9);
      check("post_rst_sum", {24'd0, s}, 32'h07);

`ifdef SERIAL_SUB_EN
      run8(8'h10, 8'h01, 1'b0, 1'b1, s, co, dc, bc, s_hold);
      $display("sub: 10-01 -> sum=%02h cout=%0d", s, co);
      check("sub1_sum",  {24'd0, s},  32'h0F);
      check("sub1_cout", {31'd0, co}, 32'd1);
      run8(8'h00, 8'h01, 1'b0, 1'b1, s, co, dc, bc, s_hold);
      $display("sub: 00-01 -> sum=%02h cout=%0d", s, co);
      check("sub2_sum",  {24'd0, s},  32'hFF);
      check("sub2_cout", {31'd0, co}, 32'd0);
`endif

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         r = ref_op(ra, rb, rc, rs);
         run8(ra, rb, rc, rs, s, co, dc, bc, s_hold);
         $display("rand %0d: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d (model %02h %0d)",
                  i, ra, rb, rc, rs, s, co, r[7:0], r[8]);
         check("rand_sum",  {24'd0, s},  {24'd0, r[7:0]});
         check("rand_cout", {31'd0, co}, {31'd0, r[8]});
         check("rand_done_cycle", dc, 32'd9);
      end

      // WIDTH=1: one RUN cycle, done in cycle 2, back-to-back start in cycle 3
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_c1_busy", {31'd0, bus1.busy}, 32'd1);
      check("w1_c1_done", {31'd0, bus1.done}, 32'd0);
      @(negedge clk);
      $display("w1: 1+1+1 -> done=%0d sum=%0d cout=%0d", bus1.done, bus1.sum, bus1.cout);
      check("w1_c2_done", {31'd0, bus1.done}, 32'd1);
      check("w1_c2_busy", {31'd0, bus1.busy}, 32'd0);
      check("w1_sum",  {31'd0, bus1.sum},  32'd1);
      check("w1_cout", {31'd0, bus1.cout}, 32'd1);
      @(negedge clk);
      check("w1_c3_done", {31'd0, bus1.done}, 32'd0);
      bus1.a = 1'b0; bus1.b = 1'b1; bus1.cin = 1'b0; bus1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_b2b_busy", {31'd0, bus1.busy}, 32'd1);
      @(negedge clk);
      $display("w1: 0+1+0 -> done=%0d sum=%0d cout=%0d", bus1.done, bus1.sum, bus1.cout);
      check("w1_b2b_done", {31'd0, bus1.done}, 32'd1);
      check("w1_b2b_sum",  {31'd0, bus1.sum},  32'd1);
      check("w1_b2b_cout", {31'd0, bus1.cout}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
